// File: rtl/link_receiver.sv
// Receive end of the two-player link: 8N1 UART deserialiser, link-frame decoder
// and a watchdog that flags a silent or broken peer on con_error.
module link_receiver #(
    parameter int CLK_FREQ       = 75_000_000,
    parameter int BAUD           = 115_200,
    parameter int TIMEOUT_CYCLES = 75_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       link_en,
    output logic [1:0] dir2,
    output logic       rcvdir,
    output logic [5:0] seed_x,
    output logic [5:0] seed_y,
    output logic       seed_valid,
    output logic       start_game,
    output logic       con_error,
    output logic       frame_err
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int WD_W         = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_MAX    = WD_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic       {DEC_HDR, DEC_WAIT_Y} dec_state_t;

    logic             rx_meta, rx_s;
    rx_state_t        rx_state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             byte_valid;
    logic [7:0]       byte_data;

    dec_state_t       dec_state;
    logic [5:0]       pend_x;
    logic [WD_W-1:0]  wd_cnt;
    logic             frame_ok, proto_err;

    // Synchroniser resets to the idle-high line level so reset release is not a start edge.
    // NOTE: all clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state   <= RX_IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        clk_cnt  <= '0;
                        bit_cnt  <= '0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt  <= '0;
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt   <= '0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt  <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_s) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shift_reg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Classify the incoming byte: completes a valid frame, breaks the protocol, or neither.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        frame_ok  = 1'b0;
        proto_err = 1'b0;
        if (byte_valid) begin
            if (dec_state == DEC_WAIT_Y) begin
                if (byte_data[7:6] == 2'b11) frame_ok = 1'b1;
                else                         proto_err = 1'b1;
            end else begin
                case (byte_data[7:6])
                    2'b00: begin
                        if (byte_data[5:2] == 4'd0) frame_ok = 1'b1;
                        else                        proto_err = 1'b1;
                    end
                    2'b01: frame_ok = 1'b0;
                    2'b10: begin
                        if (byte_data[5:0] == 6'h2A) frame_ok = 1'b1;
                        else                         proto_err = 1'b1;
                    end
                    default: proto_err = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dec_state  <= DEC_HDR;
            pend_x     <= '0;
            dir2       <= 2'd0;
            rcvdir     <= 1'b0;
            seed_x     <= '0;
            seed_y     <= '0;
            seed_valid <= 1'b0;
            start_game <= 1'b0;
            wd_cnt     <= '0;
            con_error  <= 1'b0;
        end else begin
            rcvdir     <= 1'b0;
            seed_valid <= 1'b0;
            start_game <= 1'b0;
            if (byte_valid) begin
                if (proto_err) begin
                    dec_state <= DEC_HDR;
                    pend_x    <= '0;
                end else if (dec_state == DEC_WAIT_Y) begin
                    seed_x     <= pend_x;
                    seed_y     <= byte_data[5:0];
                    seed_valid <= 1'b1;
                    pend_x     <= '0;
                    dec_state  <= DEC_HDR;
                end else begin
                    case (byte_data[7:6])
                        2'b00: begin
                            dir2   <= byte_data[1:0];
                            rcvdir <= 1'b1;
                        end
                        2'b01: begin
                            pend_x    <= byte_data[5:0];
                            dec_state <= DEC_WAIT_Y;
                        end
                        2'b10:   start_game <= 1'b1;
                        default: ;
                    endcase
                end
            end

            // A frame completing on the timeout cycle takes priority over the timeout.
            if (!link_en || frame_ok)  wd_cnt <= '0;
            else if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;

            if (frame_ok)                                    con_error <= 1'b0;
            else if (proto_err || (link_en && wd_cnt == WD_LAST)) con_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_link_receiver.sv
// Directed bench for link_receiver at 16 clocks per bit and a 2000-cycle watchdog.
module tb_link_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       link_en = 1'b0;
    logic [1:0] dir2;
    logic       rcvdir, seed_valid, start_game, con_error, frame_err;
    logic [5:0] seed_x, seed_y;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int start_cyc = 0;
    int lat = 156;
    int c0 = 0;
    int n_rcvdir = 0, n_seed = 0, n_start = 0, n_ferr = 0, n_bv = 0, n_conerr = 0;
    int b_rcvdir = 0, b_seed = 0, b_start = 0, b_ferr = 0, b_bv = 0, b_conerr = 0;
    int rcvdir_cyc = 0, bv_cyc = 0;

    link_receiver #(
        .CLK_FREQ(1_843_200),
        .BAUD(115_200),
        .TIMEOUT_CYCLES(2000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .link_en(link_en),
        .dir2(dir2),
        .rcvdir(rcvdir),
        .seed_x(seed_x),
        .seed_y(seed_y),
        .seed_valid(seed_valid),
        .start_game(start_game),
        .con_error(con_error),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rcvdir) begin
            n_rcvdir   <= n_rcvdir + 1;
            rcvdir_cyc <= cyc;
        end
        if (dut.byte_valid) begin
            n_bv   <= n_bv + 1;
            bv_cyc <= cyc;
        end
        if (seed_valid) n_seed <= n_seed + 1;
        if (start_game) n_start <= n_start + 1;
        if (frame_err)  n_ferr <= n_ferr + 1;
        if (con_error)  n_conerr <= n_conerr + 1;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        b_rcvdir = n_rcvdir; b_seed = n_seed; b_start = n_start;
        b_ferr = n_ferr; b_bv = n_bv; b_conerr = n_conerr;
    endtask

    // Called at a negedge; leaves the line high at a negedge right after the stop bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        start_cyc = cyc;
        idle(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(16);
        end
        rx = stop_bit;
        idle(16);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        tests_run++; if (dir2 !== 2'd0) begin tests_failed++; $display("FAIL reset_dir2: got %0d expected 0", dir2); end
        tests_run++; if (seed_x !== 6'd0 || seed_y !== 6'd0) begin tests_failed++; $display("FAIL reset_seed: got %0h/%0h expected 0/0", seed_x, seed_y); end
        tests_run++; if ({rcvdir, seed_valid, start_game, frame_err} !== 4'b0) begin tests_failed++; $display("FAIL reset_pulses: got %b expected 0000", {rcvdir, seed_valid, start_game, frame_err}); end
        tests_run++; if (con_error !== 1'b0) begin tests_failed++; $display("FAIL reset_con_error: got %b expected 0", con_error); end
    endtask

    task automatic test_direction();
        snap();
        send_byte(8'h02, 1'b1);
        idle(4);
        tests_run++; if (n_rcvdir - b_rcvdir !== 1) begin tests_failed++; $display("FAIL dir_pulse_count: got %0d expected 1", n_rcvdir - b_rcvdir); end
        tests_run++; if (rcvdir_cyc !== bv_cyc + 1) begin tests_failed++; $display("FAIL dir_latency: got cycle %0d expected %0d", rcvdir_cyc, bv_cyc + 1); end
        tests_run++; if (dir2 !== 2'd2) begin tests_failed++; $display("FAIL dir_value: got %0d expected 2", dir2); end
        tests_run++; if ((n_seed - b_seed) + (n_start - b_start) + (n_ferr - b_ferr) !== 0) begin tests_failed++; $display("FAIL dir_other_pulses: got %0d expected 0", (n_seed - b_seed) + (n_start - b_start) + (n_ferr - b_ferr)); end
        lat = rcvdir_cyc - start_cyc;
        idle(30);
        tests_run++; if (dir2 !== 2'd2 || n_rcvdir - b_rcvdir !== 1) begin tests_failed++; $display("FAIL dir_hold: got dir2=%0d pulses=%0d expected 2/1", dir2, n_rcvdir - b_rcvdir); end
    endtask

    task automatic test_seed();
        snap();
        send_byte(8'h5B, 1'b1);
        send_byte(8'hE7, 1'b1);
        idle(4);
        tests_run++; if (n_seed - b_seed !== 1) begin tests_failed++; $display("FAIL seed_pulse_count: got %0d expected 1", n_seed - b_seed); end
        tests_run++; if (seed_x !== 6'h1B) begin tests_failed++; $display("FAIL seed_x: got %0h expected 1b", seed_x); end
        tests_run++; if (seed_y !== 6'h27) begin tests_failed++; $display("FAIL seed_y: got %0h expected 27", seed_y); end
        tests_run++; if (n_rcvdir - b_rcvdir !== 0 || con_error !== 1'b0) begin tests_failed++; $display("FAIL seed_side_effects: got rcvdir=%0d con_error=%b expected 0/0", n_rcvdir - b_rcvdir, con_error); end

        snap();
        send_byte(8'h5B, 1'b1);
        send_byte(8'h02, 1'b1);
        idle(4);
        tests_run++; if ((n_seed - b_seed) + (n_rcvdir - b_rcvdir) !== 0) begin tests_failed++; $display("FAIL seed_bad_y_pulses: got %0d expected 0", (n_seed - b_seed) + (n_rcvdir - b_rcvdir)); end
        tests_run++; if (con_error !== 1'b1) begin tests_failed++; $display("FAIL seed_bad_y_con_error: got %b expected 1", con_error); end
        tests_run++; if (seed_x !== 6'h1B || dir2 !== 2'd2) begin tests_failed++; $display("FAIL seed_bad_y_hold: got x=%0h dir2=%0d expected 1b/2", seed_x, dir2); end

        snap();
        send_byte(8'h01, 1'b1);
        idle(4);
        tests_run++; if (n_rcvdir - b_rcvdir !== 1 || dir2 !== 2'd1) begin tests_failed++; $display("FAIL seed_recover_dir: got pulses=%0d dir2=%0d expected 1/1", n_rcvdir - b_rcvdir, dir2); end
        tests_run++; if (con_error !== 1'b0) begin tests_failed++; $display("FAIL seed_recover_con_error: got %b expected 0", con_error); end
    endtask

    task automatic test_start();
        snap();
        send_byte(8'hAA, 1'b1);
        idle(4);
        tests_run++; if (n_start - b_start !== 1 || con_error !== 1'b0) begin tests_failed++; $display("FAIL start_good: got pulses=%0d con_error=%b expected 1/0", n_start - b_start, con_error); end
        snap();
        send_byte(8'hAB, 1'b1);
        idle(4);
        tests_run++; if (n_start - b_start !== 0) begin tests_failed++; $display("FAIL start_bad_pulse: got %0d expected 0", n_start - b_start); end
        tests_run++; if (con_error !== 1'b1) begin tests_failed++; $display("FAIL start_bad_con_error: got %b expected 1", con_error); end
    endtask

    task automatic test_framing();
        snap();
        send_byte(8'h03, 1'b0);
        idle(30);
        tests_run++; if (n_ferr - b_ferr !== 1) begin tests_failed++; $display("FAIL frame_err_pulse: got %0d expected 1", n_ferr - b_ferr); end
        tests_run++; if (n_rcvdir - b_rcvdir !== 0 || dir2 !== 2'd1) begin tests_failed++; $display("FAIL frame_err_discard: got pulses=%0d dir2=%0d expected 0/1", n_rcvdir - b_rcvdir, dir2); end
        tests_run++; if (con_error !== 1'b1) begin tests_failed++; $display("FAIL frame_err_con_error: got %b expected 1", con_error); end

        snap();
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(40);
        tests_run++; if ((n_bv - b_bv) + (n_ferr - b_ferr) + (n_rcvdir - b_rcvdir) + (n_seed - b_seed) + (n_start - b_start) !== 0) begin tests_failed++; $display("FAIL glitch_activity: got %0d events expected 0", (n_bv - b_bv) + (n_ferr - b_ferr) + (n_rcvdir - b_rcvdir) + (n_seed - b_seed) + (n_start - b_start)); end

        snap();
        send_byte(8'h45, 1'b1);
        send_byte(8'hE0, 1'b0);
        idle(30);
        send_byte(8'hC9, 1'b1);
        idle(4);
        tests_run++; if (n_seed - b_seed !== 1 || n_ferr - b_ferr !== 1) begin tests_failed++; $display("FAIL split_seed_pulses: got seed=%0d ferr=%0d expected 1/1", n_seed - b_seed, n_ferr - b_ferr); end
        tests_run++; if (seed_x !== 6'h05 || seed_y !== 6'h09) begin tests_failed++; $display("FAIL split_seed_value: got %0h/%0h expected 05/09", seed_x, seed_y); end
        tests_run++; if (con_error !== 1'b0) begin tests_failed++; $display("FAIL split_seed_con_error: got %b expected 0", con_error); end
    endtask

    task automatic test_watchdog();
        send_byte(8'h00, 1'b1);
        idle(4);
        tests_run++; if (dir2 !== 2'd0 || con_error !== 1'b0) begin tests_failed++; $display("FAIL wd_pre: got dir2=%0d con_error=%b expected 0/0", dir2, con_error); end

        link_en = 1'b1;
        c0 = cyc;
        idle(1999);
        tests_run++; if (con_error !== 1'b0) begin tests_failed++; $display("FAIL wd_before_timeout: got %b expected 0", con_error); end
        idle(1);
        tests_run++; if (con_error !== 1'b1) begin tests_failed++; $display("FAIL wd_at_timeout: got %b expected 1", con_error); end

        link_en = 1'b0;
        idle(50);
        tests_run++; if (con_error !== 1'b1) begin tests_failed++; $display("FAIL wd_disable_holds: got %b expected 1", con_error); end
        send_byte(8'h00, 1'b1);
        idle(4);
        tests_run++; if (con_error !== 1'b0) begin tests_failed++; $display("FAIL wd_clear_by_frame: got %b expected 0", con_error); end

        link_en = 1'b1;
        c0 = cyc;
        idle(2000 - lat);
        snap();
        send_byte(8'h00, 1'b1);
        idle(100);
        tests_run++; if (n_conerr - b_conerr !== 0) begin tests_failed++; $display("FAIL wd_same_cycle: got %0d error cycles expected 0", n_conerr - b_conerr); end
        tests_run++; if (n_rcvdir - b_rcvdir !== 1) begin tests_failed++; $display("FAIL wd_same_cycle_frame: got %0d expected 1", n_rcvdir - b_rcvdir); end
        while (cyc < c0 + 3999) @(negedge clk);
        tests_run++; if (con_error !== 1'b0) begin tests_failed++; $display("FAIL wd_reload_before: got %b expected 0", con_error); end
        idle(1);
        tests_run++; if (con_error !== 1'b1) begin tests_failed++; $display("FAIL wd_reload_timeout: got %b expected 1", con_error); end
        link_en = 1'b0;
        idle(4);
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        send_byte(8'h03, 1'b1);
        idle(4);
        send_byte(8'hC0, 1'b1);
        idle(4);
        send_byte(8'h5B, 1'b1);
        idle(4);
        tests_run++; if (dir2 !== 2'd3 || con_error !== 1'b1) begin tests_failed++; $display("FAIL pre_reset_state: got dir2=%0d con_error=%b expected 3/1", dir2, con_error); end

        b = 8'h5B;
        rx = 1'b0;
        idle(16);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            idle(16);
        end
        rx = b[4];
        idle(8);
        rst = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(2);
        rst = 1'b1;
        snap();
        idle(200);
        tests_run++; if (dir2 !== 2'd0 || seed_x !== 6'd0 || seed_y !== 6'd0) begin tests_failed++; $display("FAIL midreset_outputs: got dir2=%0d x=%0h y=%0h expected 0/0/0", dir2, seed_x, seed_y); end
        tests_run++; if (con_error !== 1'b0) begin tests_failed++; $display("FAIL midreset_con_error: got %b expected 0", con_error); end
        tests_run++; if ((n_bv - b_bv) + (n_ferr - b_ferr) + (n_rcvdir - b_rcvdir) + (n_seed - b_seed) + (n_start - b_start) !== 0) begin tests_failed++; $display("FAIL midreset_partial: got %0d events expected 0", (n_bv - b_bv) + (n_ferr - b_ferr) + (n_rcvdir - b_rcvdir) + (n_seed - b_seed) + (n_start - b_start)); end

        snap();
        send_byte(8'hE7, 1'b1);
        idle(4);
        tests_run++; if (n_seed - b_seed !== 0 || seed_y !== 6'd0) begin tests_failed++; $display("FAIL midreset_no_seed: got pulses=%0d y=%0h expected 0/0", n_seed - b_seed, seed_y); end
        tests_run++; if (con_error !== 1'b1) begin tests_failed++; $display("FAIL midreset_proto_err: got %b expected 1", con_error); end
    endtask

    initial begin
        rst = 1'b0;
        rx = 1'b1;
        link_en = 1'b0;
        idle(5);
        rst = 1'b1;
        idle(5);
        test_reset();
        test_direction();
        test_seed();
        test_start();
        test_framing();
        test_watchdog();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/link_receiver.md
# link_receiver

Serial receive end of the two-player link. Deserialises 8N1 UART bytes from the peer board on `rx` and decodes them into link frames: the opponent's direction, the food seed and the start-game command. It also watches for a silent or broken link. Its outputs feed `move` (`dir2`, `rcvdir`), `generate_point` (seed inputs) and `mode_control` (`start_game`, `con_error`).

## Interface
- `CLK_FREQ`, default 75_000_000: clock frequency in Hz.
- `BAUD`, default 115_200: line rate. `CLKS_PER_BIT = CLK_FREQ / BAUD`, integer division (651 at the defaults).
- `TIMEOUT_CYCLES`, default 75_000_000: maximum gap between valid frames while the watchdog is armed.
- `clk`, in, 1: system clock (75 MHz domain).
- `rst`, in, 1: asynchronous, active-low reset.
- `rx`, in, 1: serial line, asynchronous to `clk`, idle high.
- `link_en`, in, 1: arms the watchdog (high while mode is GAME).
- `dir2`, out, 2 (`direction`): last received opponent direction.
- `rcvdir`, out, 1: one-cycle pulse when a direction frame is received.
- `seed_x`, `seed_y`, out, 6 each: last received seed.
- `seed_valid`, out, 1: one-cycle pulse when a complete seed frame is received.
- `start_game`, out, 1: one-cycle pulse on a valid start frame.
- `con_error`, out, 1: level output; link lost or protocol broken.
- `frame_err`, out, 1: one-cycle pulse when a byte is discarded for a bad stop bit.

## Operation
- **Input synchronisation.** `rx` passes through 2 flops; the synchroniser resets to 1. All logic below uses the synchronised `rx_s`.
- **UART FSM states.** IDLE, START, DATA, STOP.
  - IDLE: wait for a falling edge (`rx_s`=0). Clear the bit counter and go to START.
  - START: wait `CLKS_PER_BIT/2` cycles, then sample. If `rx_s`=1 it was a false start: go to IDLE. Otherwise go to DATA.
  - DATA: sample every `CLKS_PER_BIT` cycles, 8 samples, LSB first, shifted into the byte register.
  - STOP: one `CLKS_PER_BIT` later, sample the stop bit.
    - Stop bit = 1: pulse internal `byte_valid` with the byte.
    - Stop bit = 0: pulse `frame_err` and discard the byte.
    - In both cases return to IDLE. No line-idle wait is needed, because the next start is edge-detected from IDLE.
- **Frame decoder.** Header byte is `{type[1:0], payload[5:0]}`.
  - Type 00 (direction): `dir2 <= payload[1:0]` (`snake_pkg` direction encoding) and pulse `rcvdir`. `payload[5:2]` must be 0, otherwise protocol error.
  - Type 01 (seed, first byte): latch `payload` as the pending x. Go to decoder state WAIT_Y.
  - WAIT_Y: the next byte must have `[7:6]`=11. If so, `seed_x <= pending x`, `seed_y <= byte[5:0]` and pulse `seed_valid`. Both seed outputs update in the same cycle.
  - Type 10 (start): payload must be 6'h2A. If so, pulse `start_game`, otherwise protocol error.
  - Type 11 received in HDR state: protocol error.
- **Protocol error.**
  - Discard the byte, drop any pending x, and go to decoder state HDR.
  - Set `con_error`.
  - No output pulse is generated.
- **Valid frames.** A valid frame is a correct direction, seed or start frame. It reloads the watchdog and clears `con_error`.
- **Watchdog.**
  - Counts while `link_en`=1 and is reloaded by each valid frame.
  - Reaching `TIMEOUT_CYCLES` sets `con_error`. The counter saturates there.
  - `link_en`=0 holds the counter at 0 but does not clear `con_error`.
- **Errors that do not affect the decoder.** `frame_err` does not change decoder state and does not set `con_error`. A frame split by a discarded byte is simply resumed with the next good byte.

## Timing
- **Reset values.** `dir2`=UP (enum value 0), `seed_x`=0, `seed_y`=0, all pulse outputs 0, `con_error`=0, both FSMs in IDLE/HDR, watchdog counter 0.
- **Reset mid-byte or mid-frame.** Aborts immediately. Nothing partial is emitted after release.
- **Latency.**
  - `byte_valid` is asserted the cycle after the stop-bit sample.
  - Decoded outputs (`dir2`, seeds) update, and their pulses assert, on the cycle after `byte_valid`.
  - `dir2` and the seed outputs hold until the next valid frame.
- **Pulse width.** Each of `rcvdir`, `seed_valid`, `start_game` and `frame_err` is exactly 1 cycle per event.
- **Same-cycle byte and timeout.** When a valid byte completes a frame in the same cycle the watchdog reaches `TIMEOUT_CYCLES`, the valid frame wins: `con_error` stays 0 and the counter reloads.
- **Back-to-back bytes.** Must be accepted with zero idle bits between the stop bit and the next start bit.
- **Baud tolerance.** Mid-bit sampling tolerates ±2% baud mismatch.

## Test plan
Bench parameters: `CLKS_PER_BIT`=16 and `TIMEOUT_CYCLES`=2000.

1. **Direction frame.** Send byte 0x02 → `rcvdir` pulses once, 1 cycle after `byte_valid`. `dir2`=2 and holds; no other pulses.
2. **Seed frame.** Send 0x5B then 0xE7 back-to-back → single `seed_valid` with `seed_x`=0x1B and `seed_y`=0x27.
   - Variant: 0x5B then 0x02 → no pulses, `con_error`=1. A following 0x01 gives `rcvdir`, `dir2`=1 and `con_error`=0.
3. **Start frame.** Send 0xAA → `start_game` pulse. Send 0xAB → no pulse, `con_error`=1.
4. **Framing and glitches.**
   - Byte 0x03 with stop bit forced 0 → `frame_err` pulse, `rcvdir` stays 0, `dir2` unchanged.
   - 4-cycle low glitch on idle `rx` → no activity.
5. **Watchdog.**
   - `link_en`=1 and no traffic → `con_error` rises at cycle 2000.
   - Deassert `link_en` → `con_error` stays 1.
   - Send 0x00 → `con_error`=0.
   - Frame completing on the timeout cycle → `con_error` stays 0.
6. **Reset mid-frame.** Assert `rst`=0 during bit 4 of 0x5B → after release all outputs are at reset values. A following 0xE7 alone gives a protocol error, not a seed.
